stream_accumulator32: RTL and testbench
=======================================

// Module: stream_accumulator32
// PURPOSE
//  Sequential front-end and consumer for the 32-bit carry-select adder datapath.
//  - Accepts a packetised stream of 32-bit operands over valid/ready.
//  - Sums each packet into a registered accumulator and presents the total
//    once per packet, with carry/overflow flags, over valid/ready.
//  - Sits between an operand source (DMA/register file) and result consumers.
// PARAMETERS
//  WIDTH  32  operand/accumulator width; must be a multiple of 8 (carry-select block size)
//  CNT_W  16  width of the beat counter reported with each result
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat
//  in_data    in   WIDTH    operand, treated as both unsigned and two's complement
//  in_last    in   1        final beat of packet; qualified by in_valid
//  out_valid  out  1        packet result valid
//  out_ready  in   1        consumer accepts result
//  out_sum    out  WIDTH    packet sum modulo 2^WIDTH
//  out_carry  out  1        sticky: any unsigned carry-out during the packet
//  out_ovf    out  1        sticky: any signed overflow during the packet
//  out_count  out  CNT_W    beats accepted in packet; saturates at all-ones
// BEHAVIOUR
//  - Reset (async assert, clears immediately): state=IDLE.
//    acc, out_sum, out_count, out_carry, out_ovf, out_valid are all 0. in_ready=0 while rst=1.
//  - Beat accepted iff in_valid & in_ready at the rising edge. in_ready=1 in IDLE and ACC; 0 in HOLD.
//  - States:
//    - IDLE: on accept, acc<=0+in_data, count<=1, flags from that add.
//      in_last -> HOLD; otherwise -> ACC.
//    - ACC: on accept, acc<=acc+in_data, count<=count+1 (saturating).
//      carry|=cout, ovf|=(acc[MSB]==in_data[MSB])&(sum[MSB]!=acc[MSB]).
//      in_last -> HOLD. No accept -> stay ACC, acc unchanged.
//    - HOLD: out_valid=1. out_sum, out_count, out_carry, out_ovf stable while out_valid & !out_ready.
//      out_ready -> IDLE next cycle, out_valid deasserts.
//  - Latency: result valid the cycle after the edge that accepts the in_last beat.
//  - Throughput: 1 beat/cycle within a packet. One bubble minimum between packets:
//    the HOLD handshake cycle, then IDLE.
//  - Adder carry-in is always 0. The adder path is combinational between the acc register
//    and the acc/out register; it is the critical path.
//  - Single-beat packet (in_last on first beat) is legal: sum=in_data, count=1, flags 0.
//  - Count saturation: at all-ones it holds; summing continues normally.
//  - in_last with in_valid=0 is ignored. in_data/in_last may change freely when not accepted.
//  - Reset mid-packet or mid-HOLD discards the partial/pending result. No output follows
//    until a new packet completes.
//  - out_ready while not in HOLD is ignored.
// STRUCTURE
//  - Package accum_pkg:
//    - state enum {IDLE, ACC, HOLD}
//    - ACC_WIDTH=32, CS_BLOCK=8 constants
//    - function signed_ovf(a_msb, b_msb, s_msb)
//  - Sub-module adder32_cs: combinational WIDTH-bit carry-select adder with 8-bit blocks.
//    - Duplicate sums for carry-in 0/1 per block, mux on block carry.
//    - Ports a, b, cin, sum, cout.
//  - Top holds the FSM, acc/count/flag registers and output registers.
// TESTING
//  1. Packet 5,7,(last)9, out_ready=1 -> out_valid 1 cycle after 3rd accept;
//     sum=21, count=3, carry=0, ovf=0.
//  2. 0xFFFFFFFF then (last)0x00000002 -> sum=0x00000001, carry=1, ovf=0.
//  3. 0x7FFFFFFF then (last)0x00000001 -> sum=0x80000000, carry=0, ovf=1.
//  4. Single beat 0xDEADBEEF with in_last, out_ready held 0 for 4 cycles:
//     - out_valid and out_sum stay stable, in_ready=0 throughout.
//     - Release -> IDLE, next packet accepted.
//  5. Assert rst mid-packet after 2 beats, then send (last)3 -> sum=3, count=1;
//     outputs 0 during reset.
//  6. CNT_W=2, 5-beat packet of 1s -> sum=5, count=3 (saturated); random in_valid gaps
//     give identical result.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and helpers for the packet accumulator.
// State encoding, datapath sizing and signed-overflow rule.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int ACC_WIDTH = 32;
  localparam int CS_BLOCK  = 8;

  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/stream_accumulator32_if.sv
// Operand stream in, packet result out.
// master = operand source / result consumer, slave = accumulator.
interface stream_accumulator32_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_carry, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum,
    output out_carry, out_ovf, out_count
  );
endinterface

// File: rtl/adder32_cs.sv
// Carry-select adder: each block precomputes sums for
// carry-in 0 and 1, the incoming block carry picks one.
module adder32_cs
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NB = WIDTH / CS_BLOCK;

  logic [NB:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [CS_BLOCK:0] r0;
    logic [CS_BLOCK:0] r1;

    assign r0 = {1'b0, a[g*CS_BLOCK +: CS_BLOCK]}
              + {1'b0, b[g*CS_BLOCK +: CS_BLOCK]};
    assign r1 = {1'b0, a[g*CS_BLOCK +: CS_BLOCK]}
              + {1'b0, b[g*CS_BLOCK +: CS_BLOCK]}
              + {{CS_BLOCK{1'b0}}, 1'b1};

    assign sum[g*CS_BLOCK +: CS_BLOCK] =
      c[g] ? r1[CS_BLOCK-1:0] : r0[CS_BLOCK-1:0];
    assign c[g+1] = c[g] ? r1[CS_BLOCK] : r0[CS_BLOCK];
  end

  assign cout = c[NB];

endmodule

// File: rtl/stream_accumulator32.sv
// Sums each operand packet and presents total, beat
// count and sticky carry/overflow once per packet.
module stream_accumulator32
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  stream_accumulator32_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             ovf_beat;
  logic             accept;

  // First beat of a packet adds onto zero, later beats onto acc.
  assign add_a = (state_q == ACC) ? acc_q : '0;

  adder32_cs #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign ovf_beat = signed_ovf(add_a[WIDTH-1],
                               bus.in_data[WIDTH-1],
                               add_sum[WIDTH-1]);

  assign bus.in_ready = !rst && (state_q != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_carry = carry_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state: accumulate beats, hold result until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_sum;
          cnt_d   = CNT_W'(1);
          carry_d = add_cout;
          ovf_d   = ovf_beat;
          state_d = bus.in_last ? HOLD : ACC;
          valid_d = bus.in_last;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = add_sum;
          cnt_d   = (cnt_q == '1) ? cnt_q
                                  : cnt_q + CNT_W'(1);
          carry_d = carry_q | add_cout;
          ovf_d   = ovf_q | ovf_beat;
          state_d = bus.in_last ? HOLD : ACC;
          valid_d = bus.in_last;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset drops any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_stream_accumulator32.sv
// Scoreboard bench: two accumulators (16-bit and 2-bit count)
// share stimulus; a packet-level model predicts each result.
module tb_stream_accumulator32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [31:0] in_data;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 1;

  always #5 clk = ~clk;

  stream_accumulator32_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
  stream_accumulator32_if #(.WIDTH(32), .CNT_W(2))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  stream_accumulator32 #(.WIDTH(32), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  stream_accumulator32 #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Packet-level reference state.
  logic [31:0] m_acc;
  logic        m_carry;
  logic        m_ovf;
  int          m_n;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%h required=%h t=%0t",
                 nm, act, req, $time);
    end
  endtask

  task automatic mon(input string t, input bit has,
                     input exp_t e, input logic v,
                     input logic r, input logic [31:0] s,
                     input logic c, input logic o,
                     input logic [15:0] n);
    if (has) begin
      cmp({t, "_out_valid"}, {31'b0, v}, 32'd1);
      cmp({t, "_in_ready_hold"}, {31'b0, r}, 32'd0);
      cmp({t, "_sum"}, s, e.sum);
      cmp({t, "_carry"}, {31'b0, c}, {31'b0, e.carry});
      cmp({t, "_ovf"}, {31'b0, o}, {31'b0, e.ovf});
      cmp({t, "_count"}, {16'b0, n}, {16'b0, e.cnt});
    end else begin
      cmp({t, "_out_valid_idle"}, {31'b0, v}, 32'd0);
      cmp({t, "_in_ready"}, {31'b0, r}, 32'd1);
    end
  endtask

  // Monitor: outputs compared mid-cycle against queue heads.
  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    ea = '{default: '0};
    eb = '{default: '0};
    if (rst) begin
      cmp("rst_a_valid", {31'b0, bus_a.out_valid}, 32'd0);
      cmp("rst_a_ready", {31'b0, bus_a.in_ready}, 32'd0);
      cmp("rst_a_sum", bus_a.out_sum, 32'd0);
      cmp("rst_a_count", {16'b0, bus_a.out_count}, 32'd0);
      cmp("rst_a_flags",
          {30'b0, bus_a.out_carry, bus_a.out_ovf}, 32'd0);
      cmp("rst_b_valid", {31'b0, bus_b.out_valid}, 32'd0);
      cmp("rst_b_count", {30'b0, bus_b.out_count}, 32'd0);
    end else begin
      if (qa.size() > 0) ea = qa[0];
      if (qb.size() > 0) eb = qb[0];
      mon("a", qa.size() > 0, ea, bus_a.out_valid,
          bus_a.in_ready, bus_a.out_sum, bus_a.out_carry,
          bus_a.out_ovf, bus_a.out_count);
      mon("b", qb.size() > 0, eb, bus_b.out_valid,
          bus_b.in_ready, bus_b.out_sum, bus_b.out_carry,
          bus_b.out_ovf, {14'b0, bus_b.out_count});
      if (out_ready) begin
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
      end
    end
  end

  // Consumer readiness: 0 = stall, 1 = always, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic model_clear();
    m_acc   = '0;
    m_carry = 1'b0;
    m_ovf   = 1'b0;
    m_n     = 0;
  endtask

  task automatic model_beat(input logic [31:0] d,
                            input bit last);
    logic [32:0] wide;
    longint      ssum;
    exp_t        e;
    wide = {1'b0, m_acc} + {1'b0, d};
    ssum = longint'($signed(m_acc)) + longint'($signed(d));
    m_carry = m_carry | wide[32];
    if (ssum > 64'sd2147483647 || ssum < -64'sd2147483648)
      m_ovf = 1'b1;
    m_acc = wide[31:0];
    m_n++;
    if (last) begin
      e.sum   = m_acc;
      e.carry = m_carry;
      e.ovf   = m_ovf;
      e.cnt   = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
      qa.push_back(e);
      e.cnt   = (m_n > 3) ? 16'd3 : 16'(m_n);
      qb.push_back(e);
      model_clear();
    end
  endtask

  // Present one beat after gap idle cycles; wait for acceptance.
  task automatic send(input logic [31:0] d, input bit last,
                      input int gap);
    bit ok;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      model_beat(d, last);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_clear();
    qa.delete();
    qb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int k = 0; k < 100; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0",
               qa.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    model_clear();
    #2;
    do_reset();

    rdy_mode = 1;
    send(32'd5, 0, 0);
    send(32'd7, 0, 0);
    send(32'd9, 1, 0);
    drain();

    send(32'hFFFF_FFFF, 0, 1);
    send(32'h0000_0002, 1, 0);
    drain();

    send(32'h7FFF_FFFF, 0, 0);
    send(32'h0000_0001, 1, 0);
    drain();

    rdy_mode  = 0;
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    rdy_mode  = 1;
    out_ready = 1'b1;
    send(32'd11, 0, 0);
    send(32'd12, 1, 0);
    drain();

    send(32'd100, 0, 0);
    send(32'd200, 0, 0);
    do_reset();
    send(32'd3, 1, 0);
    drain();

    for (int i = 0; i < 5; i++) send(32'd1, i == 4, 0);
    drain();
    for (int i = 0; i < 5; i++)
      send(32'd1, i == 4, $urandom_range(0, 3));
    drain();

    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        logic [31:0] d;
        case ($urandom_range(0, 3))
          0:       d = 32'h7FFF_FFF0 + $urandom_range(0, 31);
          1:       d = 32'h8000_0000 + $urandom_range(0, 31);
          default: d = $urandom;
        endcase
        send(d, i == len - 1, $urandom_range(0, 2));
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
